// File: rtl/hls_stream_chan_fifo_bank_pkg.sv
// Shared types and helpers for the HLS stream channel FIFO bank.
// Contents:
//   chan_state_e - per-channel transfer state (IDLE / RUN / DRAIN)
//   occ_width()  - bit width needed to represent an occupancy of 0..depth
package hls_stream_bank_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } chan_state_e;

    // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hls_stream_chan_fifo_bank_chan.sv
// One stream channel: FIFO storage with wrap-bit pointers, a transfer FSM,
// a programmable transfer length and an accepted-beat counter.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync soft clear)
//   enable_i             - gates acceptance of new pushes only
//   start_i, len_i       - start a transfer of len_i beats (sampled in IDLE)
//   push_valid_i/push_ready_o/push_data_i - producer handshake
//   pop_valid_o/pop_ready_i/pop_data_o    - consumer handshake
//   busy_o  - transfer in RUN or DRAIN
//   done_o  - one-cycle pulse when a transfer finishes
//   occ_o   - current FIFO occupancy
//   beats_o - pushes accepted in the current or last transfer
module hls_stream_chan_fifo
    import hls_stream_bank_package::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int OCC_WIDTH  = occ_width(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [OCC_WIDTH-1:0]  occ_o,
    output logic [CNT_WIDTH-1:0]  beats_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r;
    logic [AW:0]           rd_ptr_r;
    logic [CNT_WIDTH-1:0]  len_r;
    logic [CNT_WIDTH-1:0]  beats_r;
    logic                  done_r;
    chan_state_e           state_r;
    chan_state_e           state_nxt_s;

    logic empty_s;
    logic full_s;
    logic run_s;
    logic drain_s;
    logic push_ready_s;
    logic push_fire_s;
    logic pop_fire_s;
    logic last_beat_s;
    logic start_run_s;
    logic start_zero_s;
    logic done_set_s;

    // Pointers carry one extra wrap bit: equal means empty, equal index with
    // differing wrap bits means full.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    // No bypass: a full FIFO refuses a push even when a pop happens this cycle.
    assign push_ready_s = run_s && enable_i && !full_s && (beats_r < len_r);
    assign push_fire_s  = push_valid_i && push_ready_s;
    assign pop_fire_s   = pop_ready_i && !empty_s;
    assign last_beat_s  = ((beats_r + CNT_ONE) == len_r);

    assign start_run_s  = (state_r == IDLE) && start_i && (len_i != CNT_ZERO);
    assign start_zero_s = (state_r == IDLE) && start_i && (len_i == CNT_ZERO);

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; clear overrides everything including start.
    always_comb begin
        state_nxt_s = state_r;
        if (clear_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_run_s) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    if (push_fire_s && last_beat_s) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                DRAIN: begin
                    if (empty_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        run_s   = 1'b0;
        drain_s = 1'b0;
        case (state_r)
            IDLE:    begin
                run_s   = 1'b0;
                drain_s = 1'b0;
            end
            RUN:     run_s   = 1'b1;
            DRAIN:   drain_s = 1'b1;
            default: begin
                run_s   = 1'b0;
                drain_s = 1'b0;
            end
        endcase
    end

    // done fires on a zero-length start or when DRAIN sees an empty FIFO.
    assign done_set_s = start_zero_s || (drain_s && empty_s);

    // Done pulse register: high for exactly the cycle after entry to IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_r <= 1'b0;
        end else if (clear_i) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_set_s;
        end
    end

    // Transfer length latch and accepted-beat counter (held in IDLE).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_r   <= CNT_ZERO;
            beats_r <= CNT_ZERO;
        end else if (clear_i) begin
            len_r   <= CNT_ZERO;
            beats_r <= CNT_ZERO;
        end else if (start_run_s) begin
            len_r   <= len_i;
            beats_r <= CNT_ZERO;
        end else if (push_fire_s) begin
            beats_r <= beats_r + CNT_ONE;
        end
    end

    // FIFO read/write pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (clear_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents need no reset because empty masks the read port.
    always_ff @(posedge clk_i) begin
        if (push_fire_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data_i;
        end
    end

    assign push_ready_o = push_ready_s;
    assign pop_valid_o  = !empty_s;
    assign pop_data_o   = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
    assign busy_o       = run_s || drain_s;
    assign done_o       = done_r;
    assign occ_o        = OCC_WIDTH'(wr_ptr_r - rd_ptr_r);
    assign beats_o      = beats_r;

endmodule

// File: rtl/hls_stream_chan_fifo_bank.sv
// N-channel bank of independent stream FIFOs between HWPE streamers and an
// HLS core. Each channel is a hls_stream_chan_fifo; this level only slices
// the flat per-channel buses.
// Ports (all per-channel buses are flat, channel 0 in the low slice):
//   clk_i, rst_i (async, active-high), clear_i, enable_i
//   start_i[N_CH], len_i[N_CH*CNT_WIDTH]
//   push_valid_i/push_ready_o/push_data_i, pop_valid_o/pop_ready_i/pop_data_o
//   busy_o, done_o, occ_o[N_CH*occ width], beats_o[N_CH*CNT_WIDTH]
module hls_stream_chan_fifo_bank
    import hls_stream_bank_package::*;
#(
    parameter int N_CH       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       clear_i,
    input  logic                                       enable_i,
    input  logic [N_CH-1:0]                            start_i,
    input  logic [N_CH*CNT_WIDTH-1:0]                  len_i,
    input  logic [N_CH-1:0]                            push_valid_i,
    output logic [N_CH-1:0]                            push_ready_o,
    input  logic [N_CH*DATA_WIDTH-1:0]                 push_data_i,
    output logic [N_CH-1:0]                            pop_valid_o,
    input  logic [N_CH-1:0]                            pop_ready_i,
    output logic [N_CH*DATA_WIDTH-1:0]                 pop_data_o,
    output logic [N_CH-1:0]                            busy_o,
    output logic [N_CH-1:0]                            done_o,
    output logic [N_CH*occ_width(FIFO_DEPTH)-1:0]      occ_o,
    output logic [N_CH*CNT_WIDTH-1:0]                  beats_o
);

    localparam int OW = occ_width(FIFO_DEPTH);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
        hls_stream_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_WIDTH  (CNT_WIDTH),
            .OCC_WIDTH  (OW)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .clear_i      (clear_i),
            .enable_i     (enable_i),
            .start_i      (start_i[ch]),
            .len_i        (len_i[ch*CNT_WIDTH +: CNT_WIDTH]),
            .push_valid_i (push_valid_i[ch]),
            .push_ready_o (push_ready_o[ch]),
            .push_data_i  (push_data_i[ch*DATA_WIDTH +: DATA_WIDTH]),
            .pop_valid_o  (pop_valid_o[ch]),
            .pop_ready_i  (pop_ready_i[ch]),
            .pop_data_o   (pop_data_o[ch*DATA_WIDTH +: DATA_WIDTH]),
            .busy_o       (busy_o[ch]),
            .done_o       (done_o[ch]),
            .occ_o        (occ_o[ch*OW +: OW]),
            .beats_o      (beats_o[ch*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_hls_stream_chan_fifo_bank.sv
// Self-checking bench for hls_stream_chan_fifo_bank (2 channels, depth 4).
// A queue-based reference model predicts every output each cycle; directed
// phases add scenario-level checks on counts and timing.
module tb_hls_stream_chan_fifo_bank;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int FD = 4;
    localparam int CW = 16;
    localparam int OW = 3;

    logic            clk;
    logic            rst;
    logic            clear;
    logic            enable;
    logic [N-1:0]    start;
    logic [N*CW-1:0] len;
    logic [N-1:0]    push_valid;
    logic [N-1:0]    push_ready;
    logic [N*DW-1:0] push_data;
    logic [N-1:0]    pop_valid;
    logic [N-1:0]    pop_ready;
    logic [N*DW-1:0] pop_data;
    logic [N-1:0]    busy;
    logic [N-1:0]    done;
    logic [N*OW-1:0] occ;
    logic [N*CW-1:0] beats;

    hls_stream_chan_fifo_bank #(
        .N_CH(N), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
        .start_i(start), .len_i(len),
        .push_valid_i(push_valid), .push_ready_o(push_ready), .push_data_i(push_data),
        .pop_valid_o(pop_valid), .pop_ready_i(pop_ready), .pop_data_o(pop_data),
        .busy_o(busy), .done_o(done), .occ_o(occ), .beats_o(beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: 0 = idle, 1 = accepting pushes, 2 = waiting to drain.
    int          m_mode [N];
    int          m_len  [N];
    int          m_beats[N];
    bit          m_done [N];
    logic [DW-1:0] m_q  [N][$];

    int done_cnt [N];
    int acc_cnt  [N];
    int done_time[N];
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_mode[c] = 0; m_len[c] = 0; m_beats[c] = 0; m_done[c] = 1'b0;
            m_q[c].delete();
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            done_cnt[c] = 0; acc_cnt[c] = 0; done_time[c] = -1;
        end
    endtask

    function automatic bit exp_ready(input int c);
        return (m_mode[c] == 1) && enable && (m_q[c].size() < FD) && (m_beats[c] < m_len[c]);
    endfunction

    // Compare every DUT output with the model (mid-cycle, inputs stable).
    task automatic compare_all();
        logic [N-1:0]    er, ev, eb, ed;
        logic [N*OW-1:0] eo;
        logic [N*CW-1:0] ebt;
        for (int c = 0; c < N; c++) begin
            er[c] = exp_ready(c);
            ev[c] = (m_q[c].size() > 0);
            eb[c] = (m_mode[c] != 0);
            ed[c] = m_done[c];
            eo[c*OW +: OW]  = OW'(m_q[c].size());
            ebt[c*CW +: CW] = CW'(m_beats[c]);
        end
        chk("push_ready", 64'(push_ready), 64'(er));
        chk("pop_valid",  64'(pop_valid),  64'(ev));
        chk("busy",       64'(busy),       64'(eb));
        chk("done",       64'(done),       64'(ed));
        chk("occ",        64'(occ),        64'(eo));
        chk("beats",      64'(beats),      64'(ebt));
        for (int c = 0; c < N; c++) begin
            if (ev[c]) chk("pop_data", 64'(pop_data[c*DW +: DW]), 64'(m_q[c][0]));
            if (done[c] === 1'b1) begin done_cnt[c]++; done_time[c] = cyc; end
            if (push_valid[c] && push_ready[c] === 1'b1) acc_cnt[c]++;
        end
    endtask

    // Advance the model across one rising edge using the applied inputs.
    task automatic model_update();
        bit push, pop, nd;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            push = push_valid[c] && exp_ready(c);
            pop  = pop_ready[c] && (m_q[c].size() > 0);
            nd   = 1'b0;
            if (clear) begin
                m_q[c].delete();
                m_mode[c] = 0; m_len[c] = 0; m_beats[c] = 0;
            end else begin
                if (m_mode[c] == 2 && m_q[c].size() == 0) begin
                    m_mode[c] = 0; nd = 1'b1;
                end else if (m_mode[c] == 0 && start[c]) begin
                    if (len[c*CW +: CW] == 16'd0) nd = 1'b1;
                    else begin
                        m_mode[c] = 1; m_len[c] = int'(len[c*CW +: CW]); m_beats[c] = 0;
                    end
                end
                if (pop) void'(m_q[c].pop_front());
                if (push) begin
                    m_q[c].push_back(push_data[c*DW +: DW]);
                    m_beats[c]++;
                    if (m_beats[c] == m_len[c]) m_mode[c] = 2;
                end
            end
            m_done[c] = nd;
        end
    endtask

    task automatic step();
        push_data = {$urandom(), $urandom()};
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic run_until(input logic [N-1:0] mask, input int budget);
        logic [N-1:0] seen;
        for (int i = 0; i < budget; i++) begin
            for (int c = 0; c < N; c++) seen[c] = (done_cnt[c] > 0);
            if ((seen & mask) == mask) break;
            step();
        end
        for (int c = 0; c < N; c++) seen[c] = (done_cnt[c] > 0);
        chk("done_wait", 64'(seen & mask), 64'(mask));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; enable = 1'b1; start = '0; len = '0;
        push_valid = '0; pop_ready = '0; push_data = '0;
        model_reset();
        clear_counts();
        step(); step();
        rst = 1'b0;
        step();

        // Smoke: ch0 len 5, consumer always ready.
        clear_counts();
        pop_ready = 2'b01; push_valid = 2'b01;
        start = 2'b01; len = {16'd0, 16'd5};
        step();
        start = '0; len = '0;
        run_until(2'b01, 40);
        chk("smoke_acc",   64'(acc_cnt[0]), 64'd5);
        chk("smoke_done",  64'(done_cnt[0]), 64'd1);
        chk("smoke_beats", 64'(beats[CW-1:0]), 64'd5);
        step(); step();

        // Backpressure: len 8, consumer stalled until FIFO fills.
        clear_counts();
        pop_ready = 2'b00; push_valid = 2'b01;
        start = 2'b01; len = {16'd0, 16'd8};
        step();
        start = '0; len = '0;
        repeat (6) step();
        chk("bp_occ",   64'(occ[OW-1:0]), 64'd4);
        chk("bp_ready", 64'(push_ready[0]), 64'd0);
        chk("bp_acc",   64'(acc_cnt[0]), 64'd4);
        pop_ready = 2'b01;
        run_until(2'b01, 60);
        chk("bp_acc_all", 64'(acc_cnt[0]), 64'd8);
        chk("bp_done",    64'(done_cnt[0]), 64'd1);
        step(); step();

        // Zero-length start on ch1.
        clear_counts();
        push_valid = 2'b11; pop_ready = 2'b00;
        start = 2'b10; len = '0;
        step();
        start = '0;
        repeat (3) step();
        chk("len0_done", 64'(done_cnt[1]), 64'd1);
        chk("len0_acc",  64'(acc_cnt[1]), 64'd0);

        // Clear during DRAIN with three words buffered.
        clear_counts();
        pop_ready = 2'b00; push_valid = 2'b01;
        start = 2'b01; len = {16'd0, 16'd3};
        step();
        start = '0; len = '0;
        repeat (4) step();
        chk("clr_occ_pre",  64'(occ[OW-1:0]), 64'd3);
        chk("clr_busy_pre", 64'(busy[0]), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_occ",   64'(occ[OW-1:0]), 64'd0);
        chk("clr_valid", 64'(pop_valid[0]), 64'd0);
        chk("clr_busy",  64'(busy[0]), 64'd0);
        step(); step();
        chk("clr_nodone", 64'(done_cnt[0]), 64'd0);
        pop_ready = 2'b01;
        start = 2'b01; len = {16'd0, 16'd2};
        step();
        start = '0; len = '0;
        run_until(2'b01, 30);
        chk("clr_restart_done", 64'(done_cnt[0]), 64'd1);
        step(); step();

        // Independence and enable gating; restart of busy ch0 is ignored.
        clear_counts();
        pop_ready = 2'b11; push_valid = 2'b11;
        start = 2'b11; len = {16'd6, 16'd3};
        step();
        start = '0; len = '0;
        enable = 1'b0;
        repeat (4) step();
        chk("en_block", 64'(acc_cnt[0] + acc_cnt[1]), 64'd0);
        enable = 1'b1;
        step();
        start = 2'b01; len = {16'd0, 16'd9};
        step();
        start = '0; len = '0;
        run_until(2'b11, 80);
        chk("ind_done0",  64'(done_cnt[0]), 64'd1);
        chk("ind_done1",  64'(done_cnt[1]), 64'd1);
        chk("ind_apart",  64'(done_time[0] != done_time[1]), 64'd1);
        chk("ind_beats0", 64'(beats[CW-1:0]), 64'd3);
        chk("ind_beats1", 64'(beats[2*CW-1:CW]), 64'd6);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            start      = ($urandom_range(0, 5) == 0) ? N'($urandom()) : '0;
            len        = {16'($urandom_range(0, 9)), 16'($urandom_range(0, 9))};
            push_valid = N'($urandom());
            pop_ready  = N'($urandom());
            enable     = ($urandom_range(0, 7) != 0);
            clear      = ($urandom_range(0, 99) == 0);
            step();
        end
        clear = 1'b0; start = '0; len = '0; enable = 1'b1;

        // Asynchronous reset in the middle of a transfer.
        pop_ready = 2'b00; push_valid = 2'b11;
        step();
        start = 2'b11; len = {16'd9, 16'd9};
        step();
        start = '0; len = '0;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_occ",   64'(occ), 64'd0);
        chk("arst_valid", 64'(pop_valid), 64'd0);
        chk("arst_busy",  64'(busy), 64'd0);
        chk("arst_beats", 64'(beats), 64'd0);
        chk("arst_ready", 64'(push_ready), 64'd0);
        step();
        rst = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
